// File: rtl/sha256_msched_if.sv
// Stream bundle for the SHA-256 message schedule: serial message words in,
// round words W_t with round index and first/last framing out.
interface sha256_msched_if;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] wt_out;
  logic        wt_valid;
  logic [5:0]  t_out;
  logic        wt_first;
  logic        wt_last;

  modport master (
    output in_word, in_valid,
    input  in_ready, wt_out, wt_valid, t_out, wt_first, wt_last
  );

  modport slave (
    input  in_word, in_valid,
    output in_ready, wt_out, wt_valid, t_out, wt_first, wt_last
  );
endinterface

// File: rtl/sha256_msched.sv
// SHA-256 message schedule: loads 16 words into a shift window, then streams W_t one per cycle.
// Define SHA256_MSCHED_KWSUM_EN to emit W_t + K_t from an on-chip K ROM instead of raw W_t.
module sha256_msched #(
  parameter int NROUNDS = 64
) (
  input  logic            clk,
  input  logic            rst,
  sha256_msched_if.slave  bus
);

  if ((NROUNDS < 16) || (NROUNDS > 64)) begin : g_bad_nrounds
    $error("sha256_msched: NROUNDS must be within 16..64");
  end

  typedef enum logic {LOAD, RUN} state_e;

  localparam logic [5:0] LAST_RND = 6'(NROUNDS - 1);

`ifdef SHA256_MSCHED_KWSUM_EN
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [5:0]  rnd_q, rnd_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] w_new;

  logic [31:0] wt_out_q, wt_out_d;
  logic        wt_valid_q, wt_valid_d;
  logic [5:0]  t_q, t_d;
  logic        first_q, first_d;
  logic        last_q, last_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rnd_d   = rnd_q;
    w_d     = w_q;
    w_new   = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    unique case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = bus.in_word;
          wcnt_d  = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) begin
            state_d = RUN;
            rnd_d   = '0;
          end
        end
      end
      RUN: begin
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new;
        rnd_d   = rnd_q + 6'd1;
        if (rnd_q == LAST_RND) begin
          state_d = LOAD;
          wcnt_d  = '0;
          rnd_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Outputs are computed from next-state values so the registers present W_t in the same cycle the window holds it.
  always_comb begin
    wt_valid_d = (state_d == RUN);
    t_d        = rnd_d;
    first_d    = (state_d == RUN) && (rnd_d == 6'd0);
    last_d     = (state_d == RUN) && (rnd_d == LAST_RND);
    wt_out_d   = '0;
    if (state_d == RUN) begin
`ifdef SHA256_MSCHED_KWSUM_EN
      wt_out_d = w_d[0] + K_ROM[rnd_d];
`else
      wt_out_d = w_d[0];
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      wcnt_q     <= '0;
      rnd_q      <= '0;
      // NOTE: the window is a register file that must be cleared, so each entry is reset explicitly.
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      wt_out_q   <= '0;
      wt_valid_q <= 1'b0;
      t_q        <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rnd_q      <= rnd_d;
      w_q        <= w_d;
      wt_out_q   <= wt_out_d;
      wt_valid_q <= wt_valid_d;
      t_q        <= t_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  assign bus.in_ready = (state_q == LOAD);
  assign bus.wt_out   = wt_out_q;
  assign bus.wt_valid = wt_valid_q;
  assign bus.t_out    = t_q;
  assign bus.wt_first = first_q;
  assign bus.wt_last  = last_q;

endmodule

// File: tb/tb_sha256_msched.sv
// Scoreboard bench for sha256_msched: a 64-round and a 16-round instance, directed "abc" and
// pattern blocks, bubbles, input held during RUN, back-to-back loading and mid-RUN reset.
module tb_sha256_msched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_msched_if bus64();
  sha256_msched_if bus16();

  sha256_msched #(.NROUNDS(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));
  sha256_msched #(.NROUNDS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  typedef struct {
    logic [5:0]  t;
    logic [31:0] w;
    logic        first;
    logic        last;
  } exp_t;

  exp_t q64[$];
  exp_t q16[$];

  int checks = 0;
  int errors = 0;
  int nv64   = 0;
  int nv16   = 0;

  logic [31:0] blk   [16];
  logic [31:0] ref_w [64];

`ifdef SHA256_MSCHED_KWSUM_EN
  logic [31:0] k_tb [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook array form of the schedule recurrence, indexed by absolute t.
  task automatic compute_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) ref_w[t] = blk[t];
      else ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                    + ref_w[t-7]
                    + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                    + ref_w[t-16];
    end
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0F1E2D3C ^ (32'(i) * 32'h11111111);
  endtask

  task automatic push_expected(input int which, input int n, input bit is_abc);
    exp_t e;
    compute_ref();
    for (int t = 0; t < n; t++) begin
      e.t     = 6'(t);
      e.w     = ref_w[t];
      if (is_abc && t == 16) e.w = 32'h61626380;
      if (is_abc && t == 17) e.w = 32'h000F0000;
`ifdef SHA256_MSCHED_KWSUM_EN
      e.w     = e.w + k_tb[t];
      if (is_abc && t == 0) e.w = 32'hA3EC9318;
`endif
      e.first = (t == 0);
      e.last  = (t == n - 1);
      if (which == 16) q16.push_back(e);
      else q64.push_back(e);
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [31:0] d);
    if (which == 16) begin bus16.in_valid = v; bus16.in_word = d; end
    else begin bus64.in_valid = v; bus64.in_word = d; end
  endtask

  function automatic logic rdy(input int which);
    return (which == 16) ? bus16.in_ready : bus64.in_ready;
  endfunction

  function automatic logic vld(input int which);
    return (which == 16) ? bus16.wt_valid : bus64.wt_valid;
  endfunction

  function automatic logic lst(input int which);
    return (which == 16) ? bus16.wt_last : bus64.wt_last;
  endfunction

  function automatic logic fst(input int which);
    return (which == 16) ? bus16.wt_first : bus64.wt_first;
  endfunction

  // Inputs change 1 time unit after the rising edge; the word is accepted on the next edge.
  task automatic send_block(input int which, input bit bubbles, input bit hold, input bit is_abc);
    int budget;
    push_expected(which, which, is_abc);
    for (int i = 0; i < 16; i++) begin
      if (bubbles && (i % 2 == 1)) begin
        drive(which, 1'b0, 32'hBAD00000 | 32'(i));
        @(posedge clk); #1;
      end
      drive(which, 1'b1, blk[i]);
      budget = 0;
      while (!rdy(which) && budget < 100) begin
        @(posedge clk); #1;
        budget++;
      end
      check("in_ready_wait", {31'd0, rdy(which)}, 32'd1);
      @(posedge clk); #1;
    end
    drive(which, hold, hold ? 32'hDEADBEEF : 32'h0);
    check("w0_latency", {30'd0, vld(which), fst(which)}, 32'd3);
  endtask

  task automatic wait_last(input int which, input int budget);
    int n = 0;
    while (!lst(which) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("wt_last_seen", {31'd0, lst(which)}, 32'd1);
  endtask

  task automatic after_block(input int which, input int nexp);
    @(posedge clk); #1;
    check("ready_after_last", {31'd0, rdy(which)}, 32'd1);
    check("valid_after_last", {31'd0, vld(which)}, 32'd0);
    check("valid_cycles", (which == 16) ? nv16 : nv64, nexp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus64.wt_valid === 1'b1) begin
      nv64++;
      check("rdy64_in_run", {31'd0, bus64.in_ready}, 32'd0);
      if (q64.size() == 0) check("unexpected_w64", {26'd0, bus64.t_out}, 32'hFFFFFFFF);
      else begin
        e = q64.pop_front();
        check($sformatf("w64[t=%0d]", e.t), bus64.wt_out, e.w);
        check($sformatf("t64[t=%0d]", e.t), {26'd0, bus64.t_out}, {26'd0, e.t});
        check($sformatf("fl64[t=%0d]", e.t), {30'd0, bus64.wt_first, bus64.wt_last}, {30'd0, e.first, e.last});
      end
    end
    if (bus16.wt_valid === 1'b1) begin
      nv16++;
      check("rdy16_in_run", {31'd0, bus16.in_ready}, 32'd0);
      if (q16.size() == 0) check("unexpected_w16", {26'd0, bus16.t_out}, 32'hFFFFFFFF);
      else begin
        e = q16.pop_front();
        check($sformatf("w16[t=%0d]", e.t), bus16.wt_out, e.w);
        check($sformatf("t16[t=%0d]", e.t), {26'd0, bus16.t_out}, {26'd0, e.t});
        check($sformatf("fl16[t=%0d]", e.t), {30'd0, bus16.wt_first, bus16.wt_last}, {30'd0, e.first, e.last});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    drive(64, 1'b0, 32'h0);
    drive(16, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus64.in_ready}, 32'd1);
    check("rst_wt_valid", {31'd0, bus64.wt_valid}, 32'd0);
    check("rst_flags", {30'd0, bus64.wt_first, bus64.wt_last}, 32'd0);
    check("rst_t_out", {26'd0, bus64.t_out}, 32'd0);
    check("rst_wt_out", bus64.wt_out, 32'd0);
    check("rst_in_ready16", {31'd0, bus16.in_ready}, 32'd1);
    rst = 1'b0;

    // Plain "abc" block.
    load_abc();
    nv64 = 0;
    send_block(64, 1'b0, 1'b0, 1'b1);
    wait_last(64, 100);
    after_block(64, 64);

    // Same block with a bubble before every odd word.
    nv64 = 0;
    send_block(64, 1'b1, 1'b0, 1'b1);
    wait_last(64, 100);
    after_block(64, 64);

    // Input held valid with junk during RUN, then a second block loaded right after wt_last.
    nv64 = 0;
    send_block(64, 1'b0, 1'b1, 1'b1);
    wait_last(64, 100);
    @(posedge clk); #1;
    check("b2b_ready", {31'd0, bus64.in_ready}, 32'd1);
    check("b2b_valid", {31'd0, bus64.wt_valid}, 32'd0);
    check("hold_cycles", nv64, 64);
    load_pattern();
    nv64 = 0;
    send_block(64, 1'b0, 1'b0, 1'b0);
    wait_last(64, 100);
    after_block(64, 64);

    // Reset pulsed while t=20 is on the output.
    load_abc();
    send_block(64, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!(bus64.wt_valid && bus64.t_out == 6'd20) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_t20", {26'd0, bus64.t_out}, 32'd20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q64.delete();
    check("midrun_rst_valid", {31'd0, bus64.wt_valid}, 32'd0);
    check("midrun_rst_ready", {31'd0, bus64.in_ready}, 32'd1);
    check("midrun_rst_t_out", {26'd0, bus64.t_out}, 32'd0);
    nv64 = 0;
    send_block(64, 1'b0, 1'b0, 1'b1);
    wait_last(64, 100);
    after_block(64, 64);

    // Reduced-round instance: emits the 16 loaded words only.
    nv16 = 0;
    send_block(16, 1'b0, 1'b0, 1'b1);
    wait_last(16, 40);
    after_block(16, 16);

    repeat (2) @(posedge clk);
    check("q64_drained", q64.size(), 32'd0);
    check("q16_drained", q16.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msched.md
Name: sha256_msched

Overview:
SHA-256 message schedule stage. It accepts one 512-bit padded block as 16 serial 32-bit words and expands it into the round words W_t. It streams W_t one word per cycle, one round per cycle, directly into the compression working-variable datapath. It also emits round framing flags (first/last) that the compression control uses to sequence its start-of-compression and end-of-compression behaviour.

Parameters:
NROUNDS, 64, number of W_t words emitted per block; legal range 16..64; 64 is SHA-256 compliant, lower values are for reduced-round debug.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_word  in  32  message word; the first accepted word is W0
in_valid  in  1  in_word valid
in_ready  out  1  stage can accept a message word this cycle
wt_out  out  32  round word W_t, or W_t+K_t when SHA256_MSCHED_KWSUM_EN is defined
wt_valid  out  1  wt_out/t_out valid this cycle
t_out  out  6  round index of wt_out
wt_first  out  1  high with t=0
wt_last  out  1  high with t=NROUNDS-1

Behaviour:
- Clock and reset: one clock, clk. Synchronous, active-high reset rst. rst sampled high on a clock edge forces every register to its reset value regardless of state.
- Reset values: state=LOAD, word count=0, all 16 window registers=0, round counter=0. Outputs after reset: in_ready=1, wt_valid=0, wt_first=0, wt_last=0, t_out=0, wt_out=0.
- Storage: 16x32 shift window w[0..15]. w[0] is the oldest word.
- State LOAD:
  - in_ready=1.
  - On in_valid=1: shift the window, write in_word into w[15], increment the word count.
  - in_valid=0 holds all state; bubbles between words are allowed.
  - On acceptance of the 16th word: go to RUN, clear the round counter.
- State RUN:
  - in_ready=0. in_valid and in_word are ignored; no word is accepted or lost-counted.
  - Each cycle: wt_valid=1, t_out=round counter, wt_out=w[0] (plus K_t if the option is enabled).
  - Same edge: shift the window, w[15] <= s1(w[14]) + w[9] + s0(w[1]) + w[0], all mod 2^32.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - With t=NROUNDS-1: wt_last=1, and the next state is LOAD with word count=0.
- Output registration: outputs are registered, driven from the state, window and counter. No combinational path from in_* to wt_*.
- Latency: 16th word accepted on edge N -> W0 valid in the cycle after edge N. W_t is presented t cycles later. The block occupies NROUNDS+16 cycles minimum (16 load, NROUNDS run).
- No back-pressure on the output. The consumer must take one word per cycle while wt_valid=1.
- Back-to-back blocks: in_ready rises in the cycle after wt_last. The first word of the next block can be accepted in that cycle.
- Rst mid-LOAD or mid-RUN: the partial block is discarded, the window is cleared, and wt_valid drops in the cycle after the reset edge.
- Arithmetic: all sums are 32-bit wrap-around; there is no overflow flag.
- wt_first and wt_last are both high only if NROUNDS=1; this is illegal, so the range is enforced at 16..64.

Optional Feature:
SHA256_MSCHED_KWSUM_EN.
- Defined: the block contains a 64-entry SHA-256 K_t constant ROM indexed by the round counter. wt_out = w[0] + K_t mod 2^32, so the downstream round adder saves one operand. Timing and flags are unchanged; the K_t addition is registered with no extra latency.
- Undefined: there is no ROM, and wt_out is the raw W_t.

Test Plan:
- "abc" block: words 0x61626380, 14x 0x00000000, 0x00000018 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000; wt_first at t=0, wt_last at t=63, exactly 64 wt_valid cycles.
- Same "abc" block with SHA256_MSCHED_KWSUM_EN -> first wt_out=0xA3EC9318 (W0+K0).
- in_valid toggled 1/0 during LOAD -> only the 16 valid-qualified words are captured; the RUN start is delayed by the number of bubbles; W_t is unchanged.
- in_valid held high during RUN with in_word=0xDEADBEEF -> in_ready=0 throughout and the output sequence is unaffected. The next block loads in the cycle after wt_last.
- rst pulsed at t=20 -> wt_valid=0 next cycle, in_ready=1. A fresh "abc" block then reproduces the W0..W63 reference exactly.
- NROUNDS=16 build -> emits the 16 loaded words only; wt_last at t=15.
